// File: rtl/term_screen_ctrl.sv
// term_screen_ctrl: ROWS x COLS character RAM with cursor and serial-out sequencer.
// Sits between a UART RX byte stream and a UART TX byte sender. Printable bytes are
// written at the cursor and echoed; ESC h/l/k/j move the cursor and echo the byte under
// it; ESC r replays the whole screen. Bytes arriving while busy are dropped (o_ovf sticky).
//
// Ports:
//   clk          clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   i_byte       received byte
//   i_byte_v     i_byte valid pulse
//   i_byte_done  sender finished the last byte pulse
//   o_busy       transmit sequence in progress
//   o_ovf        sticky drop flag
//   o_byte       byte to the sender (held between pulses)
//   o_byte_v     o_byte valid pulse
//   o_cursor     linear cursor index row*COLS+col
//
// Optional feature: define CURSOR_HILITE_EN to send the cell under the cursor with bit7
// set during refresh and on move echoes.

module term_screen_ctrl #(
  parameter int unsigned COLS        = 40,
  parameter int unsigned ROWS        = 24,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned CURSOR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_v,
  output logic              o_busy,
  output logic              o_ovf,
  output logic [7:0]        o_byte,
  output logic              o_byte_v,
  input  logic              i_byte_done,
  output logic [ADDR_W-1:0] o_cursor
);

  localparam int unsigned Cells = COLS * ROWS;
  localparam int unsigned ColW  = $clog2(COLS);
  localparam int unsigned RowW  = $clog2(ROWS);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(Cells - 1);
  localparam logic [ADDR_W-1:0] CurInit = ADDR_W'(CURSOR_INIT);
  localparam logic [ColW-1:0]   ColLast = ColW'(COLS - 1);
  localparam logic [ColW-1:0]   ColInit = ColW'(CURSOR_INIT % COLS);
  localparam logic [RowW-1:0]   RowLast = RowW'(ROWS - 1);
  localparam logic [RowW-1:0]   RowInit = RowW'(CURSOR_INIT / COLS);

  typedef enum logic [2:0] {StIdle, StEsc, StRd, StRdw, StSend, StWait} state_e;

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              refr_q, refr_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        obyte_q, obyte_d;
  logic              obv_q, obv_d;

  logic [7:0]        mem_q [2**ADDR_W];
  logic [7:0]        rdata_q;
  logic              we;
  logic [ADDR_W-1:0] ram_addr;
  logic              busy;

  assign busy = state_q inside {StRd, StRdw, StSend, StWait};

  // Single-port RAM, synchronous read, write-first. Not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[ram_addr] <= i_byte;
      rdata_q         <= i_byte;
    end else begin
      rdata_q <= mem_q[ram_addr];
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    cur_d    = cur_q;
    addr_d   = addr_q;
    refr_d   = refr_q;
    ovf_d    = ovf_q;
    obyte_d  = obyte_q;
    obv_d    = 1'b0;
    we       = 1'b0;
    ram_addr = addr_q;

    if (i_byte_v && busy) ovf_d = 1'b1;

    case (state_q)
      StIdle: begin
        ram_addr = cur_q;
        if (i_byte_v) begin
          if (i_byte == 8'h1B) begin
            state_d = StEsc;
          end else if (i_byte == 8'h0D) begin
            col_d = '0;
            cur_d = cur_q - ADDR_W'(col_q);
          end else if (i_byte >= 8'h20 && i_byte <= 8'h7E) begin
            we      = 1'b1;
            obyte_d = i_byte;
            obv_d   = 1'b1;
            state_d = StWait;
            if (cur_q == LastIdx) begin
              row_d = '0;
              col_d = '0;
              cur_d = '0;
            end else begin
              cur_d = cur_q + ADDR_W'(1);
              if (col_q == ColLast) begin
                col_d = '0;
                row_d = row_q + RowW'(1);
              end else begin
                col_d = col_q + ColW'(1);
              end
            end
          end
        end
      end
      StEsc: begin
        if (i_byte_v) begin
          state_d = StRd;
          case (i_byte)
            8'h68: if (col_q != '0) begin
              col_d = col_q - ColW'(1);
              cur_d = cur_q - ADDR_W'(1);
            end
            8'h6C: if (col_q != ColLast) begin
              col_d = col_q + ColW'(1);
              cur_d = cur_q + ADDR_W'(1);
            end
            8'h6B: if (row_q != '0) begin
              row_d = row_q - RowW'(1);
              cur_d = cur_q - ADDR_W'(COLS);
            end
            8'h6A: if (row_q != RowLast) begin
              row_d = row_q + RowW'(1);
              cur_d = cur_q + ADDR_W'(COLS);
            end
            8'h72:   refr_d  = 1'b1;
            default: state_d = StIdle;
          endcase
          addr_d = (i_byte == 8'h72) ? '0 : cur_d;
        end
      end
      StRd:   state_d = StRdw;
      StRdw:  state_d = StSend;
      StSend: begin
        obyte_d = rdata_q;
`ifdef CURSOR_HILITE_EN
        // A move echo always reads at the cursor, so one compare covers both cases.
        if (addr_q == cur_q) obyte_d[7] = 1'b1;
`endif
        obv_d   = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // A done coincident with our own pulse belongs to an earlier byte; ignore it.
        if (i_byte_done && !obv_q) begin
          if (refr_q && addr_q != LastIdx) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StRd;
          end else begin
            refr_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= RowInit;
      col_q   <= ColInit;
      cur_q   <= CurInit;
      addr_q  <= '0;
      refr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      obyte_q <= 8'h00;
      obv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cur_q   <= cur_d;
      addr_q  <= addr_d;
      refr_q  <= refr_d;
      ovf_q   <= ovf_d;
      obyte_q <= obyte_d;
      obv_q   <= obv_d;
    end
  end

  assign o_busy   = busy;
  assign o_ovf    = ovf_q;
  assign o_byte   = obyte_q;
  assign o_byte_v = obv_q;
  assign o_cursor = cur_q;

endmodule

// File: tb/tb_term_screen_ctrl.sv
// Self-checking bench for term_screen_ctrl: directed scenarios plus randomized byte
// streams compared against a screen model (linear cell array, row/col cursor).

module tb_term_screen_ctrl;

  localparam int COLS   = 40;
  localparam int ROWS   = 24;
  localparam int ADDR_W = 10;
  localparam int N      = COLS * ROWS;
`ifdef CURSOR_HILITE_EN
  localparam bit HL = 1'b1;
`else
  localparam bit HL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        i_byte = 8'h00;
  logic              i_byte_v = 1'b0;
  logic              i_byte_done = 1'b0;
  logic              o_busy, o_ovf, o_byte_v;
  logic [7:0]        o_byte;
  logic [ADDR_W-1:0] o_cursor;

  always #5 clk = ~clk;

  term_screen_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .CURSOR_INIT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_byte(i_byte), .i_byte_v(i_byte_v), .o_busy(o_busy),
    .o_ovf(o_ovf), .o_byte(o_byte), .o_byte_v(o_byte_v), .i_byte_done(i_byte_done),
    .o_cursor(o_cursor)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_mem [N];
  int         m_row = 0, m_col = 0;
  bit         m_esc = 1'b0, m_ovf = 1'b0;

  function automatic int m_idx();
    return m_row * COLS + m_col;
  endfunction

  function automatic logic [7:0] hl(input logic [7:0] b, input bit on);
    return (HL && on) ? (b | 8'h80) : b;
  endfunction

  // kind: 0 no output, 1 echo of written byte, 2 move echo, 3 refresh
  task automatic model_step(input logic [7:0] b, output int kind, output logic [7:0] eb);
    int idx;
    kind = 0;
    eb   = 8'h00;
    if (m_esc) begin
      m_esc = 1'b0;
      case (b)
        8'h68: begin if (m_col > 0) m_col--;        kind = 2; end
        8'h6C: begin if (m_col < COLS - 1) m_col++; kind = 2; end
        8'h6B: begin if (m_row > 0) m_row--;        kind = 2; end
        8'h6A: begin if (m_row < ROWS - 1) m_row++; kind = 2; end
        8'h72: kind = 3;
        default: kind = 0;
      endcase
      if (kind == 2) eb = hl(m_mem[m_idx()], 1'b1);
    end else if (b == 8'h1B) begin
      m_esc = 1'b1;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      m_mem[m_idx()] = b;
      eb   = b;
      kind = 1;
      idx  = (m_idx() + 1) % N;
      m_row = idx / COLS;
      m_col = idx % COLS;
    end
  endtask

  // Drive one byte, follow whatever transmit sequence it starts, check against the model.
  task automatic run_byte(input logic [7:0] b, input int dly, input int drop_at);
    int         kind, lat, cnt, exp_lat;
    logic [7:0] eb, exp_b;
    model_step(b, kind, eb);
    i_byte = b; i_byte_v = 1'b1;
    @(posedge clk); #1;
    i_byte_v = 1'b0;
    if (kind == 0) begin
      vectors++;
      if (o_byte_v !== 1'b0 || o_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL quiet byte %h: v=%b busy=%b want 0 0", b, o_byte_v, o_busy);
      end
    end else begin
      cnt = (kind == 3) ? N : 1;
      exp_lat = (kind == 1) ? 1 : 4;
      for (int i = 0; i < cnt; i++) begin
        lat = 1;
        while (o_byte_v !== 1'b1 && lat < 10) begin
          @(posedge clk); #1;
          lat++;
        end
        vectors++;
        if (o_byte_v !== 1'b1) begin
          miscompares++;
          $display("FAIL pulse timeout byte %h idx %0d: no o_byte_v", b, i);
          break;
        end
        exp_b = (kind == 3) ? hl(m_mem[i], i == m_idx()) : eb;
        vectors++;
        if (o_byte !== exp_b) begin
          miscompares++;
          $display("FAIL o_byte idx %0d: got %h want %h", i, o_byte, exp_b);
        end
        vectors++;
        if (lat != exp_lat) begin
          miscompares++;
          $display("FAIL latency idx %0d: got %0d want %0d", i, lat, exp_lat);
        end
        if (i == drop_at) begin
          i_byte = 8'h78; i_byte_v = 1'b1; m_ovf = 1'b1;
        end
        @(posedge clk); #1;
        i_byte_v = 1'b0;
        vectors++;
        if (o_byte_v !== 1'b0 || o_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL after pulse idx %0d: v=%b busy=%b want 0 1", i, o_byte_v, o_busy);
        end
        repeat (dly) begin @(posedge clk); #1; end
        i_byte_done = 1'b1;
        @(posedge clk); #1;
        i_byte_done = 1'b0;
      end
      vectors++;
      if (o_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL busy after last done: got %b want 0", o_busy);
      end
    end
    vectors++;
    if (o_cursor !== ADDR_W'(m_idx())) begin
      miscompares++;
      $display("FAIL cursor after %h: got %0d want %0d", b, o_cursor, m_idx());
    end
    vectors++;
    if (o_ovf !== m_ovf) begin
      miscompares++;
      $display("FAIL ovf after %h: got %b want %b", b, o_ovf, m_ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (o_byte !== 8'h00 || o_byte_v !== 1'b0 || o_busy !== 1'b0 || o_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset outputs: byte=%h v=%b busy=%b ovf=%b want 00 0 0 0",
               o_byte, o_byte_v, o_busy, o_ovf);
    end
    vectors++;
    if (o_cursor !== '0) begin
      miscompares++;
      $display("FAIL reset cursor: got %0d want 0", o_cursor);
    end
    rst_n = 1'b1;
    m_row = 0; m_col = 0; m_esc = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) run_byte(8'h20, 0, -1);
    vectors++;
    if (o_cursor !== '0) begin
      miscompares++;
      $display("FAIL fill wrap cursor: got %0d want 0", o_cursor);
    end
  endtask

  task automatic test_print();
    int         kind;
    logic [7:0] eb;
    model_step(8'h41, kind, eb);
    i_byte = 8'h41; i_byte_v = 1'b1;
    @(posedge clk); #1;
    i_byte_v = 1'b0;
    vectors++;
    if (o_byte_v !== 1'b1 || o_byte !== 8'h41) begin
      miscompares++;
      $display("FAIL echo A: v=%b byte=%h want 1 41", o_byte_v, o_byte);
    end
    vectors++;
    if (o_cursor !== ADDR_W'(1)) begin
      miscompares++;
      $display("FAIL cursor after A: got %0d want 1", o_cursor);
    end
    // done coincident with the pulse must be ignored
    i_byte_done = 1'b1;
    @(posedge clk); #1;
    i_byte_done = 1'b0;
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL early done accepted: busy=%b want 1", o_busy);
    end
    i_byte_done = 1'b1;
    @(posedge clk); #1;
    i_byte_done = 1'b0;
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy after done: got %b want 0", o_busy);
    end
    run_byte(8'h1B, 0, -1); run_byte(8'h68, 1, -1);
    run_byte(8'h1B, 0, -1); run_byte(8'h6B, 2, -1);
    run_byte(8'h1B, 0, -1); run_byte(8'h68, 0, -1);
  endtask

  task automatic test_refresh();
    run_byte(8'h0D, 0, -1);
    run_byte(8'h48, 1, -1);
    run_byte(8'h49, 0, -1);
    run_byte(8'h1B, 0, -1);
    run_byte(8'h72, 5, -1);
    run_byte(8'h1B, 0, -1);
    run_byte(8'h68, 0, -1);
    run_byte(8'h1B, 0, -1);
    run_byte(8'h72, $urandom_range(0, 2), 100);
  endtask

  task automatic test_wrap();
    run_byte(8'h0D, 0, -1);
    for (int i = 0; i < ROWS; i++) begin run_byte(8'h1B, 0, -1); run_byte(8'h6B, 0, -1); end
    for (int i = 0; i < COLS; i++) begin run_byte(8'h1B, 0, -1); run_byte(8'h6C, 0, -1); end
    run_byte(8'h42, 1, -1);
    vectors++;
    if (o_cursor !== ADDR_W'(COLS)) begin
      miscompares++;
      $display("FAIL row wrap cursor: got %0d want %0d", o_cursor, COLS);
    end
    for (int i = 0; i < ROWS; i++) begin run_byte(8'h1B, 0, -1); run_byte(8'h6A, 0, -1); end
    run_byte(8'h0D, 0, -1);
    for (int i = 0; i < COLS; i++) begin run_byte(8'h1B, 0, -1); run_byte(8'h6C, 0, -1); end
    vectors++;
    if (o_cursor !== ADDR_W'(N - 1)) begin
      miscompares++;
      $display("FAIL last cell cursor: got %0d want %0d", o_cursor, N - 1);
    end
    run_byte(8'h43, 0, -1);
    vectors++;
    if (o_cursor !== '0) begin
      miscompares++;
      $display("FAIL screen wrap cursor: got %0d want 0", o_cursor);
    end
  endtask

  task automatic test_ovf_reset();
    int         kind, lat;
    logic [7:0] eb;
    // byte coincident with the final done is dropped
    model_step(8'h71, kind, eb);
    i_byte = 8'h71; i_byte_v = 1'b1;
    @(posedge clk); #1;
    i_byte_v = 1'b0;
    @(posedge clk); #1;
    i_byte_done = 1'b1; i_byte = 8'h7A; i_byte_v = 1'b1; m_ovf = 1'b1;
    @(posedge clk); #1;
    i_byte_done = 1'b0; i_byte_v = 1'b0;
    vectors++;
    if (o_busy !== 1'b0 || o_ovf !== 1'b1 || o_cursor !== ADDR_W'(m_idx())) begin
      miscompares++;
      $display("FAIL done-cycle drop: busy=%b ovf=%b cur=%0d want 0 1 %0d",
               o_busy, o_ovf, o_cursor, m_idx());
    end
    @(posedge clk); #1;
    vectors++;
    if (o_byte_v !== 1'b0) begin
      miscompares++;
      $display("FAIL dropped byte echoed: v=%b want 0", o_byte_v);
    end
    // reset in the middle of a refresh, one edge before a pulse would appear
    run_byte(8'h1B, 0, -1);
    model_step(8'h72, kind, eb);
    i_byte = 8'h72; i_byte_v = 1'b1;
    @(posedge clk); #1;
    i_byte_v = 1'b0;
    for (int j = 0; j < 3; j++) begin
      lat = 0;
      while (o_byte_v !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
      vectors++;
      if (o_byte_v !== 1'b1) begin
        miscompares++;
        $display("FAIL refresh pulse timeout before reset: idx %0d", j);
      end
      @(posedge clk); #1;
      i_byte_done = 1'b1;
      @(posedge clk); #1;
      i_byte_done = 1'b0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (o_byte_v !== 1'b0 || o_busy !== 1'b0 || o_ovf !== 1'b0 || o_cursor !== '0) begin
      miscompares++;
      $display("FAIL mid-refresh reset: v=%b busy=%b ovf=%b cur=%0d want 0 0 0 0",
               o_byte_v, o_busy, o_ovf, o_cursor);
    end
    rst_n = 1'b1;
    m_row = 0; m_col = 0; m_esc = 1'b0; m_ovf = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int         r;
    logic [7:0] mv [4];
    mv[0] = 8'h68; mv[1] = 8'h6C; mv[2] = 8'h6B; mv[3] = 8'h6A;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        run_byte(8'($urandom_range(32, 126)), $urandom_range(0, 3), -1);
      end else if (r == 5) begin
        run_byte(8'h0D, 0, -1);
      end else if (r <= 7) begin
        run_byte(8'h1B, 0, -1);
        run_byte(mv[$urandom_range(0, 3)], $urandom_range(0, 3), -1);
      end else if (r == 8) begin
        run_byte(8'h1B, 0, -1);
        run_byte(8'(8'h41 + $urandom_range(0, 5)), 0, -1);
      end else begin
        run_byte(8'(8'h7F + $urandom_range(0, 128)), 0, -1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_mem[i] = 8'h00;
    test_reset();
    test_fill();
    test_print();
    test_refresh();
    test_wrap();
    test_ovf_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
